// File: rtl/result_bus_arbiter.sv
// 8-way round-robin result-bus arbiter with per-requester burst lock.
// One registered output word; a new word is captured whenever the output slot is free or drained.
module result_bus_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         req,
   input  logic [7:0]         lock,
   input  logic [8*WIDTH-1:0] in_data,
   output logic [7:0]         ack,
   output logic [WIDTH-1:0]   out_data,
   output logic [2:0]         out_sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               locked
);

   typedef enum logic {StArb, StOwned} state_e;

   state_e     state_q;
   logic [2:0] ptr_q;
   logic [2:0] owner_q;
   logic       can_load;
   logic       found;
   logic       capture;
   logic [2:0] win;
   logic [2:0] idx;

   assign can_load = !out_valid || out_ready;

   // While owned, only the owner competes; otherwise scan from ptr_q upward with wrap.
   always_comb begin
      found = 1'b0;
      win   = owner_q;
      idx   = ptr_q;
      if (state_q == StOwned) begin
         found = req[owner_q];
      end else begin
         for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && req[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
      end
   end

   assign capture = found && can_load;
   assign ack     = (capture && reset) ? (8'b1 << win) : 8'b0;
   assign locked  = (state_q == StOwned);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StArb;
         ptr_q     <= 3'd0;
         owner_q   <= 3'd0;
         out_data  <= '0;
         out_sel   <= 3'd0;
         out_valid <= 1'b0;
      end else begin
         if (capture) begin
            out_data  <= in_data[win*WIDTH +: WIDTH];
            out_sel   <= win;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         unique case (state_q)
            StArb: begin
               if (capture) begin
                  if (lock[win]) begin
                     state_q <= StOwned;
                     owner_q <= win;
                  end else begin
                     ptr_q <= win + 3'd1;
                  end
               end
            end
            StOwned: begin
               // Release on an unlocked capture or on an unlocked abandon.
               if ((capture || !req[owner_q]) && !lock[owner_q]) begin
                  state_q <= StArb;
                  ptr_q   <= owner_q + 3'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed bench for result_bus_arbiter: rotation, backpressure, bursts, abandon, wrap and reset.
module tb_result_bus_arbiter;

   localparam int unsigned WIDTH = 32;

   logic               clk = 1'b0;
   logic               reset;
   logic [7:0]         req;
   logic [7:0]         lock;
   logic [8*WIDTH-1:0] in_data;
   logic [7:0]         ack;
   logic [WIDTH-1:0]   out_data;
   logic [2:0]         out_sel;
   logic               out_valid;
   logic               out_ready;
   logic               locked;

   int checks   = 0;
   int failures = 0;

   result_bus_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .lock      (lock),
      .in_data   (in_data),
      .ack       (ack),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .locked    (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_word(input int i, input logic [31:0] v);
      in_data[i*WIDTH +: WIDTH] = v;
   endtask

   // Apply inputs, check the combinational ack, then advance one rising edge.
   task automatic cycle(input logic [7:0] r, input logic [7:0] l, input logic rdy,
                        input logic [7:0] exp_ack, input string tag);
      req       = r;
      lock      = l;
      out_ready = rdy;
      #1;
      check(tag, 32'(ack), 32'(exp_ack));
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      req       = 8'hFF;
      lock      = 8'h00;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) set_word(i, 32'(i + 100));

      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", out_data, 0);
      check("rst_sel", 32'(out_sel), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_ack", 32'(ack), 0);
      reset = 1'b1;

      // Fair rotation from ptr 0
      for (int c = 0; c < 9; c++) begin
         cycle(8'hFF, 8'h00, 1'b1, 8'h01 << (c % 8), "rr_ack");
         check("rr_sel", 32'(out_sel), 32'(c % 8));
         check("rr_data", out_data, 32'(100 + c % 8));
         check("rr_valid", 32'(out_valid), 1);
      end

      // Drain, then backpressure on requester 3 (ptr is 1)
      cycle(8'h00, 8'h00, 1'b1, 8'h00, "drain_ack");
      check("drain_valid", 32'(out_valid), 0);
      cycle(8'h08, 8'h00, 1'b0, 8'h08, "bp_first_ack");
      check("bp_first_data", out_data, 103);
      set_word(3, 203);
      for (int c = 0; c < 2; c++) begin
         cycle(8'h08, 8'h00, 1'b0, 8'h00, "bp_hold_ack");
         check("bp_hold_data", out_data, 103);
         check("bp_hold_sel", 32'(out_sel), 3);
         check("bp_hold_valid", 32'(out_valid), 1);
      end
      cycle(8'h08, 8'h00, 1'b1, 8'h08, "bp_second_ack");
      check("bp_second_data", out_data, 203);

      // Burst by 5 with req[2] pending (ptr is 4)
      for (int c = 0; c < 3; c++) begin
         set_word(5, 32'(500 + c));
         cycle(8'h24, 8'h20, 1'b1, 8'h20, "burst_ack");
         check("burst_locked", 32'(locked), 1);
         check("burst_data", out_data, 32'(500 + c));
      end
      cycle(8'h04, 8'h00, 1'b1, 8'h00, "burst_release_ack");
      check("burst_release_locked", 32'(locked), 0);
      cycle(8'h04, 8'h00, 1'b1, 8'h04, "after_burst_ack");
      check("after_burst_sel", 32'(out_sel), 2);

      // Owned by 1, then abandon with req[0] waiting (ptr is 3)
      cycle(8'h02, 8'h02, 1'b1, 8'h02, "own1_ack");
      check("own1_locked", 32'(locked), 1);
      cycle(8'h01, 8'h00, 1'b1, 8'h00, "abandon_ack");
      check("abandon_locked", 32'(locked), 0);
      check("abandon_valid", 32'(out_valid), 0);
      check("abandon_hold_sel", 32'(out_sel), 1);
      check("abandon_hold_data", out_data, 101);
      cycle(8'h01, 8'h00, 1'b1, 8'h01, "post_abandon_ack");
      check("post_abandon_sel", 32'(out_sel), 0);

      // Pointer wrap: grant 6 sets ptr 7, then 0 (ptr 1), then 7 (ptr 0)
      cycle(8'h40, 8'h00, 1'b1, 8'h40, "wrap6_ack");
      cycle(8'h01, 8'h00, 1'b1, 8'h01, "wrap0_ack");
      cycle(8'h80, 8'h00, 1'b1, 8'h80, "wrap7_ack");
      check("wrap7_sel", 32'(out_sel), 7);
      cycle(8'h81, 8'h00, 1'b1, 8'h01, "wrap_ptr0_ack");

      // Asynchronous reset while owned with a valid word
      cycle(8'h10, 8'h10, 1'b1, 8'h10, "own4_ack");
      check("own4_locked", 32'(locked), 1);
      req = 8'h10;
      #2;
      reset = 1'b0;
      #1;
      check("async_valid", 32'(out_valid), 0);
      check("async_locked", 32'(locked), 0);
      check("async_ack", 32'(ack), 0);
      check("async_sel", 32'(out_sel), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle(8'hFF, 8'h00, 1'b1, 8'h01, "post_rst_ack");
      check("post_rst_sel", 32'(out_sel), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/result_bus_arbiter.md
RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, is the data word width per requester.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 req  input  8  per-requester word-valid; bit i means in_data word i is offered.
REQ-005 lock  input  8  per-requester burst-lock; sampled with req.
REQ-006 in_data  input  8*WIDTH  word i at bits [i*WIDTH +: WIDTH].
REQ-007 ack  output  8  one-hot, combinational; bit i high means word i is captured at this edge.
REQ-008 out_data  output  WIDTH  registered result-bus word.
REQ-009 out_sel  output  3  registered index of the source of out_data; this is the 8-way mux selector.
REQ-010 out_valid  output  1  registered; out_data is valid.
REQ-011 out_ready  input  1  consumer accepts out_data at this edge when out_valid=1.
REQ-012 locked  output  1  registered; a burst owner currently holds the bus.

Function
REQ-013 can_load = !out_valid || out_ready, computed combinationally.
REQ-014 State: ptr[2:0] (round-robin start), owner[2:0], and locked. Two states: ARB (locked=0) and OWNED (locked=1).
REQ-015 ARB: the winner is the first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+7 mod 8.
REQ-016 ARB: if a winner exists and can_load=1, then:
  - ack[winner]=1 in that cycle.
  - At the edge: out_data<=word, out_sel<=winner, out_valid<=1.
REQ-017 ARB capture with lock[winner]=1: go to OWNED, owner<=winner, ptr unchanged.
REQ-018 ARB capture with lock[winner]=0: stay in ARB, ptr<=winner+1 mod 8 (7 wraps to 0).
REQ-019 OWNED: only owner is eligible, and req of all other requesters is ignored.
  - Capture when req[owner]=1 and can_load=1, with the same data path as REQ-016.
REQ-020 OWNED capture with lock[owner]=0: return to ARB, ptr<=owner+1 mod 8.
REQ-021 OWNED with req[owner]=0 and lock[owner]=0 (abandon): no capture, return to ARB, ptr<=owner+1 mod 8.
REQ-022 OWNED with req[owner]=0 and lock[owner]=1: no capture, remain OWNED.
REQ-023 ack is all-zero whenever no capture occurs; at most one ack bit is high in any cycle.
REQ-024 out_valid=1 and out_ready=0: out_data and out_sel are held stable, and no ack is raised.
REQ-025 out_ready=1 in the same cycle as a capture: the old word is consumed, the new word is loaded, and out_valid stays 1.
REQ-026 out_ready=1 with no capture: out_valid<=0, and out_data and out_sel hold their values.
REQ-027 out_ready while out_valid=0 has no effect.
REQ-028 Latency: a word offered with the bus free and the requester winning appears on out_data one edge later.
REQ-029 Fairness: with all req high and lock low, grants rotate 0,1,...,7,0 with one capture per cycle while out_ready=1.

Reset
REQ-030 While reset=0, asynchronously:
  - out_valid=0, out_data=0, out_sel=0, locked=0, owner=0, ptr=0.
  - ack=0 regardless of req.
REQ-031 Reset asserted mid-burst or with out_valid=1 discards the pending word and the lock ownership.
REQ-032 After reset is released, the first arbitration starts at ptr=0.

Verification
REQ-033 Stimulus: reset; req=8'hFF, lock=0, out_ready=1, in_data word i = i+100. Required response: ack walks 01,02,04,...,80,01; out_sel follows one cycle later; out_data=100..107.
REQ-034 Stimulus: req[3]=1, out_ready=0 for 3 cycles, then 1. Required response:
  - Word 3 is captured and ack[3] pulses once.
  - Second word is acked only in the cycle out_ready=1.
  - out_data is stable throughout.
REQ-035 Stimulus: req[5]=req[2]=1, lock[5]=1 for 3 words, ptr=4. Required response:
  - Requester 5 gets 3 consecutive captures with locked=1 and req[2] ignored.
  - After lock drops, requester 2 is served next (ptr=6 wraps to 2).
REQ-036 Stimulus: OWNED by 1, then req[1]=0 and lock[1]=0 with req[0]=1. Required response: abandon to ARB with ptr=2; requester 0 is granted in the following cycle.
REQ-037 Stimulus: reset asserted while OWNED with out_valid=1. Required response: out_valid, locked, ack and out_sel are 0 immediately, without waiting for a clock edge.
REQ-038 Stimulus: ptr=7, only req[0]=1. Required response: grant 0, ptr<=1; then only req[7]=1 gives grant 7, ptr<=0.
